// File: rtl/pipe_seg_skid.sv
// pipe_seg_skid: valid/ready pipeline segment register with an optional
// two-entry skid buffer, synchronous flush and a saturating stall counter.
// The payload is opaque. Callers pack their stage fields into in_data.
// out_data always comes from a flop, so there is no combinational in->out path.
module pipe_seg_skid #(
  parameter int DATA_W         = 32,
  parameter int SKID           = 1,
  parameter int CLEAR_ON_FLUSH = 1,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

  state_t              state_r;
  state_t              state_nxt_s;
  logic [DATA_W-1:0]   main_r;
  logic [DATA_W-1:0]   main_nxt_s;
  logic [DATA_W-1:0]   skid_r;
  logic [DATA_W-1:0]   skid_nxt_s;
  logic                out_valid_r;
  logic [1:0]          occ_r;
  logic                in_ready_r;   // skid mode: registered "not full"
  logic                rdy_en_r;     // low only until the first edge after reset
  logic [CNT_W-1:0]    stall_cnt_r;
  logic                in_ready_s;
  logic                accept_s;
  logic                emit_s;
  logic                stall_s;

  // In skid mode in_ready comes straight from a flop. Without the skid buffer
  // it is the classic combinational "free or draining" term, gated off until
  // reset has been released for one edge.
  assign in_ready_s = (SKID != 0) ? in_ready_r
                                  : (rdy_en_r && (!out_valid_r || out_ready));
  assign accept_s   = in_valid && in_ready_s;
  assign emit_s     = out_valid_r && out_ready;
  assign stall_s    = in_valid && !in_ready_s;

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = main_r;
  assign occupancy = occ_r;
  assign stall_cnt = stall_cnt_r;

  // Next-state and payload steering. The main register always holds the
  // oldest entry. The skid register is filled only while main is stalled.
  // Without the skid buffer, in_ready already forbids accept-without-emit
  // when full, so ST_TWO is never reached.
  always_comb begin
    state_nxt_s = state_r;
    main_nxt_s  = main_r;
    skid_nxt_s  = skid_r;
    if (flush) begin
      state_nxt_s = ST_EMPTY;
      if (CLEAR_ON_FLUSH != 0) begin
        main_nxt_s = ZERO_DATA;
        skid_nxt_s = ZERO_DATA;
      end else begin
        main_nxt_s = main_r;
        skid_nxt_s = skid_r;
      end
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_nxt_s = ST_ONE;
            main_nxt_s  = in_data;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && emit_s) begin
            state_nxt_s = ST_ONE;
            main_nxt_s  = in_data;
          end else if (accept_s) begin
            state_nxt_s = ST_TWO;
            skid_nxt_s  = in_data;
          end else if (emit_s) begin
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
        ST_TWO: begin
          if (emit_s) begin
            state_nxt_s = ST_ONE;
            main_nxt_s  = skid_r;
          end else begin
            state_nxt_s = ST_TWO;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
        end
      endcase
    end
  end

  // State, payload and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_EMPTY;
      main_r      <= ZERO_DATA;
      skid_r      <= ZERO_DATA;
      out_valid_r <= 1'b0;
      occ_r       <= 2'd0;
      in_ready_r  <= 1'b0;
      rdy_en_r    <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      main_r      <= main_nxt_s;
      skid_r      <= skid_nxt_s;
      out_valid_r <= (state_nxt_s != ST_EMPTY);
      occ_r       <= 2'(state_nxt_s);
      in_ready_r  <= (state_nxt_s != ST_TWO);
      rdy_en_r    <= 1'b1;
    end
  end

  // Saturating count of cycles where upstream offered data but was refused.
  // Flush leaves this counter alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

endmodule
